xosera_bus_port: RTL and testbench

//  Parametrised host-bus front end for Xosera. Synchronises the asynchronous 68k-style bus (CS/RnW/bytesel/reg/data) into clk.

---
 rtl/xosera_pkg.sv | 34 +++
 rtl/xosera_sync.sv | 43 ++++
 rtl/xosera_bus_port.sv | 225 ++++++++++++++++++++++
 tb/tb_xosera_bus_port.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xosera_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : xosera_pkg                                                   |
// | Description : Shared types and constants for the Xosera host bus port:     |
// |               bus FSM state encoding, bus pin polarities and byte-enable   |
// |               codes.                                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package xosera_pkg;

  // Bus front-end FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    WAIT_IDLE = 2'd2
  } bus_state_t;

  // Pin polarities of the 68k-style host bus
  localparam logic cs_ENABLED = 1'b0;  // chip select is active low
  localparam logic RnW_READ   = 1'b1;  // rd_nwr high means read

  // Byte enables {hi,lo}
  localparam logic [1:0] BE_HI = 2'b10;
  localparam logic [1:0] BE_LO = 2'b01;

  // Byte lane for an 8-bit host: bytesel 0 is the even (high) byte
  function automatic logic [1:0] lane_be(input logic bytesel);
    return bytesel ? BE_LO : BE_HI;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xosera_sync.sv
// +----------------------------------------------------------------------------+
// | Module      : xosera_sync                                                  |
// | Description : Multi-flop synchroniser for a single asynchronous input.     |
// |               Exposes every stage so callers can require a level to be     |
// |               seen across the whole chain (a crude pulse-width filter).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module xosera_sync #(
  parameter int   STAGES    = 2,     // must be >= 2
  parameter logic RESET_VAL = 1'b0
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              d_i,
  output logic              q_o,
  output logic [STAGES-1:0] stages_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the async input one stage further each clock
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  // Synchroniser flops
  always_ff @(posedge clk) begin
    if (reset_i) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o      = sync_q[STAGES-1];
  assign stages_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/xosera_bus_port.sv
// +----------------------------------------------------------------------------+
// | Module      : xosera_bus_port                                              |
// | Description : Host bus front end. Synchronises the async 68k-style bus,    |
// |               turns each access into one register read/write strobe,      |
// |               registers read data and drives the pin tri-state enable.    |
// |               Optional CS deglitch filter: define XOSERA_BUS_DEGLITCH_EN.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module xosera_bus_port
  import xosera_pkg::*;
#(
  parameter int DATA_W        = 8,   // 8 (byte lanes) or 16
  parameter int REG_NUM_W     = 4,
  parameter int SYNC_STAGES   = 2,   // >= 2
  parameter int MIN_CS_CYCLES = 2    // >= 1, deglitch build only
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic                 bus_cs_n_i,
  input  logic                 bus_rd_nwr_i,
  input  logic                 bus_bytesel_i,
  input  logic [REG_NUM_W-1:0] bus_reg_num_i,
  input  logic [DATA_W-1:0]    bus_data_i,
  output logic [DATA_W-1:0]    bus_data_o,
  output logic                 bus_out_ena_o,
  output logic                 reg_wr_o,
  output logic                 reg_rd_o,
  output logic [REG_NUM_W-1:0] reg_num_o,
  output logic [1:0]           reg_be_o,
  output logic [15:0]          reg_data_o,
  input  logic [15:0]          reg_data_i,
  output logic                 bus_busy_o
);

  // ---------------------------------------------------------------------------
  // CS synchroniser. Stages reset to the asserted level so a CS already held
  // when reset releases is not mistaken for a fresh idle period.
  // ---------------------------------------------------------------------------
  logic                   cs_sync;
  logic [SYNC_STAGES-1:0] cs_stages;

  xosera_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (cs_ENABLED)
  ) u_cs_sync (
    .clk      (clk),
    .reset_i  (reset_i),
    .d_i      (bus_cs_n_i),
    .q_o      (cs_sync),
    .stages_o (cs_stages)
  );

  logic cs_s_active;
  logic cs_s_idle;

  assign cs_s_active = (cs_sync == cs_ENABLED);
  // Deassertion only counts once it fills the whole chain, so gaps shorter
  // than SYNC_STAGES clocks are ignored.
  assign cs_s_idle   = (cs_stages == {SYNC_STAGES{~cs_ENABLED}});

  // Pins turn around immediately, straight from the raw bus inputs
  assign bus_out_ena_o = (bus_cs_n_i == cs_ENABLED) && (bus_rd_nwr_i == RnW_READ);

  // ---------------------------------------------------------------------------
  // State and holding registers
  // ---------------------------------------------------------------------------
  bus_state_t             state_q, state_d;
  logic                   capture;

  logic                   rd_nwr_in_q, rd_nwr_in_d;
  logic                   bytesel_in_q, bytesel_in_d;
  logic [REG_NUM_W-1:0]   reg_num_in_q, reg_num_in_d;
  logic [DATA_W-1:0]      data_in_q, data_in_d;

  logic                   rd_nwr_q, rd_nwr_d;
  logic                   bytesel_q, bytesel_d;
  logic [REG_NUM_W-1:0]   reg_num_q, reg_num_d;
  logic [1:0]             be_q, be_d;
  logic [15:0]            wdata_q, wdata_d;
  logic                   pend_q, pend_d;
  logic                   reg_wr_q, reg_wr_d;
  logic                   reg_rd_q, reg_rd_d;
  logic [DATA_W-1:0]      bus_data_q, bus_data_d;

  // Width-dependent lane handling
  logic [1:0]             be_cap;
  logic [15:0]            wdata_cap;
  logic [DATA_W-1:0]      rdata_sel;

  if (DATA_W == 16) begin : g_data16
    assign be_cap    = BE_HI | BE_LO;
    assign wdata_cap = data_in_q;
    assign rdata_sel = reg_data_i;
  end else begin : g_data8
    assign be_cap    = lane_be(bytesel_in_q);
    assign wdata_cap = {data_in_q, data_in_q};
    assign rdata_sel = bytesel_q ? reg_data_i[7:0] : reg_data_i[15:8];
  end

`ifdef XOSERA_BUS_DEGLITCH_EN
  localparam int QUAL_W = (MIN_CS_CYCLES > 1) ? $clog2(MIN_CS_CYCLES) : 1;
  logic [QUAL_W-1:0] qual_cnt_q, qual_cnt_d;
`endif

  // Next state: qualify CS in IDLE, then wait for a full deassertion
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
`ifdef XOSERA_BUS_DEGLITCH_EN
    qual_cnt_d = '0;
`endif
    case (state_q)
      IDLE: begin
`ifdef XOSERA_BUS_DEGLITCH_EN
        if (cs_s_active) begin
          if (qual_cnt_q == QUAL_W'(MIN_CS_CYCLES - 1)) begin
            capture = 1'b1;
            state_d = ACTIVE;
          end else begin
            qual_cnt_d = qual_cnt_q + 1'b1;
          end
        end
`else
        if (cs_s_active) begin
          capture = 1'b1;
          state_d = ACTIVE;
        end
`endif
      end
      ACTIVE: begin
        if (cs_s_idle) begin
          state_d = IDLE;
        end
      end
      WAIT_IDLE: begin
        if (cs_s_idle) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = WAIT_IDLE;
      end
    endcase
  end

  // Input register stage, capture on qualify, strobe one cycle after capture
  always_comb begin
    rd_nwr_in_d  = bus_rd_nwr_i;
    bytesel_in_d = bus_bytesel_i;
    reg_num_in_d = bus_reg_num_i;
    data_in_d    = bus_data_i;

    rd_nwr_d     = rd_nwr_q;
    bytesel_d    = bytesel_q;
    reg_num_d    = reg_num_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    if (capture) begin
      rd_nwr_d  = rd_nwr_in_q;
      bytesel_d = bytesel_in_q;
      reg_num_d = reg_num_in_q;
      be_d      = be_cap;
      wdata_d   = wdata_cap;
    end

    pend_d     = capture;
    reg_wr_d   = pend_q & (rd_nwr_q != RnW_READ);
    reg_rd_d   = pend_q & (rd_nwr_q == RnW_READ);
    bus_data_d = rdata_sel;
  end

  // All registers; reset wins over any concurrent bus activity
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q      <= WAIT_IDLE;
      rd_nwr_in_q  <= 1'b0;
      bytesel_in_q <= 1'b0;
      reg_num_in_q <= '0;
      data_in_q    <= '0;
      rd_nwr_q     <= 1'b0;
      bytesel_q    <= 1'b0;
      reg_num_q    <= '0;
      be_q         <= 2'b00;
      wdata_q      <= '0;
      pend_q       <= 1'b0;
      reg_wr_q     <= 1'b0;
      reg_rd_q     <= 1'b0;
      bus_data_q   <= '0;
`ifdef XOSERA_BUS_DEGLITCH_EN
      qual_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rd_nwr_in_q  <= rd_nwr_in_d;
      bytesel_in_q <= bytesel_in_d;
      reg_num_in_q <= reg_num_in_d;
      data_in_q    <= data_in_d;
      rd_nwr_q     <= rd_nwr_d;
      bytesel_q    <= bytesel_d;
      reg_num_q    <= reg_num_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      pend_q       <= pend_d;
      reg_wr_q     <= reg_wr_d;
      reg_rd_q     <= reg_rd_d;
      bus_data_q   <= bus_data_d;
`ifdef XOSERA_BUS_DEGLITCH_EN
      qual_cnt_q   <= qual_cnt_d;
`endif
    end
  end

  assign reg_wr_o   = reg_wr_q;
  assign reg_rd_o   = reg_rd_q;
  assign reg_num_o  = reg_num_q;
  assign reg_be_o   = be_q;
  assign reg_data_o = wdata_q;
  assign bus_data_o = bus_data_q;
  assign bus_busy_o = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_xosera_bus_port.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_xosera_bus_port                                           |
// | Description : Self-checking bench for xosera_bus_port. Drives one shared   |
// |               pin bus into an 8-bit and a 16-bit instance. Deglitch        |
// |               checks apply when XOSERA_BUS_DEGLITCH_EN is defined.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_xosera_bus_port;

`ifdef XOSERA_BUS_DEGLITCH_EN
  localparam int LAT = 2 + 3 + 1;
`else
  localparam int LAT = 2 + 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs_n = 1'b0;
  logic        rnw = 1'b0;
  logic        bsel = 1'b0;
  logic [3:0]  regn = '0;
  logic [15:0] din = '0;
  logic [15:0] rdv = '0;

  logic [7:0]  d8_dout;
  logic        d8_ena, d8_wr, d8_rd, d8_busy;
  logic [3:0]  d8_num;
  logic [1:0]  d8_be;
  logic [15:0] d8_wd;

  logic [15:0] d16_dout;
  logic        d16_ena, d16_wr, d16_rd, d16_busy;
  logic [3:0]  d16_num;
  logic [1:0]  d16_be;
  logic [15:0] d16_wd;

  always #5 clk = ~clk;

  xosera_bus_port #(.DATA_W(8), .REG_NUM_W(4), .SYNC_STAGES(2), .MIN_CS_CYCLES(3)) dut8 (
    .clk(clk), .reset_i(reset), .bus_cs_n_i(cs_n), .bus_rd_nwr_i(rnw),
    .bus_bytesel_i(bsel), .bus_reg_num_i(regn), .bus_data_i(din[7:0]),
    .bus_data_o(d8_dout), .bus_out_ena_o(d8_ena), .reg_wr_o(d8_wr), .reg_rd_o(d8_rd),
    .reg_num_o(d8_num), .reg_be_o(d8_be), .reg_data_o(d8_wd), .reg_data_i(rdv),
    .bus_busy_o(d8_busy)
  );

  xosera_bus_port #(.DATA_W(16), .REG_NUM_W(4), .SYNC_STAGES(2), .MIN_CS_CYCLES(3)) dut16 (
    .clk(clk), .reset_i(reset), .bus_cs_n_i(cs_n), .bus_rd_nwr_i(rnw),
    .bus_bytesel_i(bsel), .bus_reg_num_i(regn), .bus_data_i(din),
    .bus_data_o(d16_dout), .bus_out_ena_o(d16_ena), .reg_wr_o(d16_wr), .reg_rd_o(d16_rd),
    .reg_num_o(d16_num), .reg_be_o(d16_be), .reg_data_o(d16_wd), .reg_data_i(rdv),
    .bus_busy_o(d16_busy)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int base     = 0;
  int wr8, rd8, wr16, rd16, first8, first16;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_counts();
    wr8 = 0; rd8 = 0; wr16 = 0; rd16 = 0;
    first8 = -1; first16 = -1;
    base = cyc;
  endtask

  // One clock: sample strobes just after the rising edge
  task automatic sample();
    @(posedge clk);
    #1;
    cyc++;
    if (d8_wr)  wr8++;
    if (d8_rd)  rd8++;
    if (d16_wr) wr16++;
    if (d16_rd) rd16++;
    if ((d8_wr || d8_rd) && first8 < 0)    first8  = cyc;
    if ((d16_wr || d16_rd) && first16 < 0) first16 = cyc;
  endtask

  task automatic run(input logic csn, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cs_n = csn;
      sample();
    end
  endtask

  task automatic set_bus(input logic r, input logic b, input logic [3:0] rn,
                         input logic [15:0] d, input logic [15:0] rv);
    @(negedge clk);
    rnw = r; bsel = b; regn = rn; din = d; rdv = rv;
  endtask

  typedef struct {
    logic        rnw;
    logic        bsel;
    logic [3:0]  rn;
    logic [15:0] din;
    logic [15:0] rdv;
    logic [1:0]  be8;
    logic [15:0] wd8;
    logic [7:0]  do8;
  } vec_t;

  vec_t tv[6];

  initial begin
    tv[0] = '{1'b0, 1'b0, 4'h3, 16'h12A5, 16'h0000, 2'b10, 16'hA5A5, 8'h00};
    tv[1] = '{1'b0, 1'b1, 4'hF, 16'hBEEF, 16'h0000, 2'b01, 16'hEFEF, 8'h00};
    tv[2] = '{1'b1, 1'b1, 4'h2, 16'h0000, 16'h1234, 2'b01, 16'h0000, 8'h34};
    tv[3] = '{1'b1, 1'b0, 4'h0, 16'h0000, 16'h1234, 2'b10, 16'h0000, 8'h12};
    tv[4] = '{1'b0, 1'b0, 4'h7, 16'h5A3C, 16'h0000, 2'b10, 16'h3C3C, 8'h00};
    tv[5] = '{1'b1, 1'b0, 4'hA, 16'h0000, 16'hCAFE, 2'b10, 16'h0000, 8'hCA};

    // Reset held with CS asserted
    clear_counts();
    run(1'b0, 3);
    chk("rst_wr8", d8_wr, 0);
    chk("rst_rd8", d8_rd, 0);
    chk("rst_num8", d8_num, 0);
    chk("rst_be8", d8_be, 0);
    chk("rst_wd8", d8_wd, 0);
    chk("rst_dout8", d8_dout, 0);
    chk("rst_dout16", d16_dout, 0);

    // CS still asserted as reset releases: no strobe
    @(negedge clk);
    reset = 1'b0;
    clear_counts();
    run(1'b0, 20);
    chk("cs_at_reset_strobes8", wr8 + rd8, 0);
    chk("cs_at_reset_strobes16", wr16 + rd16, 0);
    chk("cs_at_reset_busy8", d8_busy, 1);
    run(1'b1, 4);
    chk("idle_busy8", d8_busy, 0);

    // Table-driven single accesses, CS low 10 clk each
    for (int v = 0; v < 6; v++) begin
      set_bus(tv[v].rnw, tv[v].bsel, tv[v].rn, tv[v].din, tv[v].rdv);
      clear_counts();
      @(negedge clk);
      cs_n = 1'b0;
      #1;
      chk($sformatf("v%0d_ena8", v), d8_ena, tv[v].rnw);
      chk($sformatf("v%0d_ena16", v), d16_ena, tv[v].rnw);
      sample();
      run(1'b0, 9);
      chk($sformatf("v%0d_wr8", v), wr8, tv[v].rnw ? 0 : 1);
      chk($sformatf("v%0d_rd8", v), rd8, tv[v].rnw ? 1 : 0);
      chk($sformatf("v%0d_wr16", v), wr16, tv[v].rnw ? 0 : 1);
      chk($sformatf("v%0d_rd16", v), rd16, tv[v].rnw ? 1 : 0);
      chk($sformatf("v%0d_lat8", v), first8 - base, LAT);
      chk($sformatf("v%0d_lat16", v), first16 - base, LAT);
      chk($sformatf("v%0d_num8", v), d8_num, tv[v].rn);
      chk($sformatf("v%0d_num16", v), d16_num, tv[v].rn);
      chk($sformatf("v%0d_be8", v), d8_be, tv[v].be8);
      chk($sformatf("v%0d_be16", v), d16_be, 2'b11);
      chk($sformatf("v%0d_busy8", v), d8_busy, 1);
      if (!tv[v].rnw) begin
        chk($sformatf("v%0d_wd8", v), d8_wd, tv[v].wd8);
        chk($sformatf("v%0d_wd16", v), d16_wd, tv[v].din);
      end else begin
        chk($sformatf("v%0d_dout8", v), d8_dout, tv[v].do8);
        chk($sformatf("v%0d_dout16", v), d16_dout, tv[v].rdv);
      end
      run(1'b1, 5);
      chk($sformatf("v%0d_total8", v), wr8 + rd8, 1);
      chk($sformatf("v%0d_ena_off8", v), d8_ena, 0);
      chk($sformatf("v%0d_idle8", v), d8_busy, 0);
    end

    // 1-clk CS gap is not seen: one strobe
    set_bus(1'b0, 1'b0, 4'h5, 16'h0101, 16'h0000);
    clear_counts();
    run(1'b0, 8);
    run(1'b1, 1);
    run(1'b0, 8);
    run(1'b1, 5);
    chk("gap1_wr8", wr8, 1);
    chk("gap1_wr16", wr16, 1);

    // 3-clk CS gap separates two accesses
    clear_counts();
    run(1'b0, 8);
    run(1'b1, 3);
    run(1'b0, 8);
    run(1'b1, 5);
    chk("gap3_wr8", wr8, 2);
    chk("gap3_wr16", wr16, 2);

    // Reset lands on the strobe cycle: strobe suppressed, no strobe while CS held
    set_bus(1'b0, 1'b1, 4'h9, 16'h0011, 16'h0000);
    clear_counts();
    run(1'b0, LAT - 1);
    @(negedge clk);
    reset = 1'b1;
    sample();
    @(negedge clk);
    reset = 1'b0;
    run(1'b0, 10);
    chk("midrst_strobes8", wr8 + rd8, 0);
    chk("midrst_strobes16", wr16 + rd16, 0);
    chk("midrst_num8", d8_num, 0);
    chk("midrst_busy8", d8_busy, 1);
    run(1'b1, 4);
    clear_counts();
    run(1'b0, 10);
    run(1'b1, 4);
    chk("after_rst_wr8", wr8, 1);
    chk("after_rst_num8", d8_num, 4'h9);
    chk("after_rst_wd8", d8_wd, 16'h1111);

`ifdef XOSERA_BUS_DEGLITCH_EN
    // 2-clk pulse filtered out, 3-clk pulse qualifies at latency 6
    set_bus(1'b0, 1'b0, 4'h6, 16'h00C3, 16'h0000);
    clear_counts();
    run(1'b0, 2);
    run(1'b1, 6);
    chk("dg_short_wr8", wr8, 0);
    chk("dg_short_wr16", wr16, 0);
    clear_counts();
    run(1'b0, 3);
    run(1'b1, 6);
    chk("dg_long_wr8", wr8, 1);
    chk("dg_long_lat8", first8 - base, 6);
    chk("dg_long_num8", d8_num, 4'h6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
